// File: rtl/int_controller.sv
// Interrupt source for the multicycle CPU: edge-detects N_IRQ maskable lines plus one NMI,
// masks and priority-encodes them, and presents one request at a time until acknowledged and EOI'd.
module int_controller #(
  parameter int N_IRQ = 8,
  parameter int VEC_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq,
  input  logic             nmi_src,
  input  logic             mask_wr,
  input  logic [N_IRQ-1:0] mask_data,
  input  logic             INTD,
  input  logic             INA,
  input  logic             isInterrupted,
  input  logic             eoi,
  output logic             INT,
  output logic             NMI,
  output logic [VEC_W-1:0] vector,
  output logic             in_service,
  output logic [N_IRQ-1:0] pending
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [N_IRQ-1:0] irq_q, mask, pending_r, eligible, irq_evt, pend_clr;
  logic             nmi_q, nmi_pend, nmi_evt, armed;
  logic             latch, ack, done;

  function automatic logic [VEC_W-1:0] prio_enc(input logic [N_IRQ-1:0] req);
    logic [VEC_W-1:0] v;
    v = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (req[i]) v = VEC_W'(i);
    return v;
  endfunction

  // armed stays low for the first edge after reset so levels already high at release
  // are absorbed into irq_q/nmi_q instead of counting as fresh rising edges.
  assign irq_evt  = armed ? (irq & ~irq_q) : '0;
  assign nmi_evt  = armed & nmi_src & ~nmi_q;
  assign eligible = pending_r & ~mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      irq_q <= '0;
      nmi_q <= 1'b0;
      mask  <= '0;
    end else begin
      armed <= 1'b1;
      irq_q <= irq;
      nmi_q <= nmi_src;
      if (mask_wr) mask <= mask_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|eligible) state_nxt = REQ;
      REQ:     if (INA)       state_nxt = SERVICE;
      SERVICE: if (eoi)       state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    latch    = (state == IDLE) && (|eligible);
    ack      = (state == REQ) && INA;
    done     = (state == SERVICE) && eoi;
    pend_clr = '0;
    for (int i = 0; i < N_IRQ; i++)
      pend_clr[i] = ack && (vector == VEC_W'(i));
  end

  // Set has priority over the acknowledge clear on the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r  <= '0;
      vector     <= '0;
      in_service <= 1'b0;
      INT        <= 1'b0;
      nmi_pend   <= 1'b0;
    end else begin
      pending_r <= (pending_r & ~pend_clr) | irq_evt;
      if (latch) vector <= prio_enc(eligible);
      if (ack)       in_service <= 1'b1;
      else if (done) in_service <= 1'b0;
      INT      <= (state_nxt == REQ) & ~INTD;
      nmi_pend <= nmi_evt | (nmi_pend & ~(isInterrupted & ~INA));
    end
  end

  assign NMI     = nmi_pend;
  assign pending = pending_r;

endmodule

// File: tb/tb_int_controller.sv
// Bench for int_controller: a vector table walked cycle by cycle through a scoreboard queue,
// then hand-written sequences for asynchronous reset and request latency.
module tb_int_controller;
  localparam int N_IRQ = 8;
  localparam int VEC_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_IRQ-1:0] irq, mask_data, pending;
  logic             nmi_src, mask_wr, INTD, INA, isInterrupted, eoi;
  logic             INT, NMI, in_service;
  logic [VEC_W-1:0] vector;

  int passed = 0;
  int total  = 0;

  int_controller #(.N_IRQ(N_IRQ), .VEC_W(VEC_W)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .nmi_src(nmi_src),
    .mask_wr(mask_wr), .mask_data(mask_data), .INTD(INTD), .INA(INA),
    .isInterrupted(isInterrupted), .eoi(eoi), .INT(INT), .NMI(NMI),
    .vector(vector), .in_service(in_service), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] irq;
    logic       mwr;
    logic [7:0] mdata;
    logic       intd, ina, isint, eoi, nmi;
    logic       e_int, e_nmi;
    logic [2:0] e_vec;
    logic       e_isv;
    logic [7:0] e_pend;
  } vec_t;

  typedef struct {
    logic       e_int, e_nmi;
    logic [2:0] e_vec;
    logic       e_isv;
    logic [7:0] e_pend;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];

  function automatic vec_t mk(logic [7:0] i, logic mw, logic [7:0] md, logic id, logic a,
                              logic ii, logic eo, logic n, logic ei, logic en,
                              logic [2:0] ev, logic es, logic [7:0] ep);
    vec_t v;
    v.irq = i; v.mwr = mw; v.mdata = md; v.intd = id; v.ina = a; v.isint = ii;
    v.eoi = eo; v.nmi = n; v.e_int = ei; v.e_nmi = en; v.e_vec = ev; v.e_isv = es;
    v.e_pend = ep;
    return v;
  endfunction

  task automatic push_exp(logic ei, logic en, logic [2:0] ev, logic es, logic [7:0] ep);
    exp_t e;
    e.e_int = ei; e.e_nmi = en; e.e_vec = ev; e.e_isv = es; e.e_pend = ep;
    sbq.push_back(e);
  endtask

  task automatic check(string name);
    exp_t e;
    total++;
    if (sbq.size() == 0) begin
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sbq.pop_front();
    if (INT === e.e_int && NMI === e.e_nmi && vector === e.e_vec &&
        in_service === e.e_isv && pending === e.e_pend)
      passed++;
    else
      $display("FAIL %s: got INT=%b NMI=%b vec=%0d isv=%b pend=%h, expected INT=%b NMI=%b vec=%0d isv=%b pend=%h",
               name, INT, NMI, vector, in_service, pending,
               e.e_int, e.e_nmi, e.e_vec, e.e_isv, e.e_pend);
  endtask

  initial begin
    int lat;
    //              irq mw md  id a ii eo n  | INT NMI vec isv pend
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0,0,0, 0,0,0,0,8'h00)); // 0 arm after reset
    tbl.push_back(mk(8'h04,0,8'h00,0,0,0,0,0, 0,0,0,0,8'h04)); // 1 event line 2
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0,0,0, 1,0,2,0,8'h04)); // 2 REQ vec 2
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0,0,0, 1,0,2,0,8'h04)); // 3 hold REQ
    tbl.push_back(mk(8'h00,0,8'h00,0,1,0,0,0, 0,0,2,1,8'h00)); // 4 ack
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0,1,0, 0,0,2,0,8'h00)); // 5 eoi
    tbl.push_back(mk(8'h28,0,8'h00,0,0,0,0,0, 0,0,2,0,8'h28)); // 6 lines 3 and 5
    tbl.push_back(mk(8'h28,0,8'h00,0,0,0,0,0, 1,0,3,0,8'h28)); // 7 held level, vec 3
    tbl.push_back(mk(8'h28,0,8'h00,0,1,0,0,0, 0,0,3,1,8'h20)); // 8
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0,1,0, 0,0,3,0,8'h20)); // 9
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0,0,0, 1,0,5,0,8'h20)); // 10 vec 5
    tbl.push_back(mk(8'h00,0,8'h00,0,1,0,0,0, 0,0,5,1,8'h00)); // 11
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0,1,0, 0,0,5,0,8'h00)); // 12
    tbl.push_back(mk(8'h00,1,8'h01,0,0,0,0,0, 0,0,5,0,8'h00)); // 13 mask line 0
    tbl.push_back(mk(8'h01,0,8'h00,0,0,0,0,0, 0,0,5,0,8'h01)); // 14 masked event
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0,0,0, 0,0,5,0,8'h01)); // 15 stays idle
    tbl.push_back(mk(8'h00,1,8'h00,0,0,0,0,0, 0,0,5,0,8'h01)); // 16 unmask
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0,0,0, 1,0,0,0,8'h01)); // 17 REQ vec 0
    tbl.push_back(mk(8'h00,0,8'h00,0,1,0,0,0, 0,0,0,1,8'h00)); // 18
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0,1,0, 0,0,0,0,8'h00)); // 19
    tbl.push_back(mk(8'h02,0,8'h00,0,0,0,0,0, 0,0,0,0,8'h02)); // 20
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0,0,0, 1,0,1,0,8'h02)); // 21 REQ vec 1
    tbl.push_back(mk(8'h00,0,8'h00,1,0,0,0,0, 0,0,1,0,8'h02)); // 22 INTD gates INT
    tbl.push_back(mk(8'h01,0,8'h00,1,0,0,0,0, 0,0,1,0,8'h03)); // 23 higher prio, vec frozen
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0,0,0, 1,0,1,0,8'h03)); // 24 INTD released
    tbl.push_back(mk(8'h00,0,8'h00,0,1,0,0,0, 0,0,1,1,8'h01)); // 25 service line 1
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0,0,1, 0,1,1,1,8'h01)); // 26 NMI in SERVICE
    tbl.push_back(mk(8'h00,0,8'h00,0,0,1,0,1, 0,0,1,1,8'h01)); // 27 NMI ack, FSM unchanged
    tbl.push_back(mk(8'h00,0,8'h00,0,1,0,0,0, 0,0,1,1,8'h01)); // 28 INA ignored in SERVICE
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0,1,0, 0,0,1,0,8'h01)); // 29 eoi
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0,1,0, 1,0,0,0,8'h01)); // 30 eoi ignored in IDLE
    tbl.push_back(mk(8'h01,0,8'h00,0,1,0,0,0, 0,0,0,1,8'h01)); // 31 set beats ack clear
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0,1,0, 0,0,0,0,8'h01)); // 32
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0,0,0, 1,0,0,0,8'h01)); // 33 re-request line 0
    tbl.push_back(mk(8'h00,0,8'h00,0,0,1,0,1, 1,1,0,0,8'h01)); // 34 NMI set beats clear
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0,0,1, 1,1,0,0,8'h01)); // 35
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0,0,0, 1,1,0,0,8'h01)); // 36
    tbl.push_back(mk(8'hFF,0,8'h00,0,0,0,0,0, 1,1,0,0,8'hFF)); // 37 all pending

    rst_n = 1'b0; irq = '0; nmi_src = 0; mask_wr = 0; mask_data = '0;
    INTD = 0; INA = 0; isInterrupted = 0; eoi = 0;
    @(negedge clk); @(negedge clk);
    push_exp(0, 0, 0, 0, 8'h00);
    check("reset_state");
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      irq = tbl[k].irq; mask_wr = tbl[k].mwr; mask_data = tbl[k].mdata;
      INTD = tbl[k].intd; INA = tbl[k].ina; isInterrupted = tbl[k].isint;
      eoi = tbl[k].eoi; nmi_src = tbl[k].nmi;
      push_exp(tbl[k].e_int, tbl[k].e_nmi, tbl[k].e_vec, tbl[k].e_isv, tbl[k].e_pend);
      @(posedge clk); #1;
      check($sformatf("vec%0d", k));
      @(negedge clk);
    end
    mask_wr = 0; INTD = 0; INA = 0; isInterrupted = 0; eoi = 0; nmi_src = 0;

    // Asynchronous reset in the middle of REQ with everything pending, irq held high.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    push_exp(0, 0, 0, 0, 8'h00);
    check("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      push_exp(0, 0, 0, 0, 8'h00);
      check($sformatf("held_after_reset%0d", c));
    end

    // Request latency on line 7, bounded wait for INT.
    @(negedge clk); irq = 8'h00;
    @(negedge clk); irq = 8'h80;
    lat = 11;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (INT === 1'b1) begin
        lat = c;
        break;
      end
    end
    total++;
    if (lat == 2) passed++;
    else $display("FAIL int_latency: got %0d edges, expected 2", lat);
    total++;
    if (vector === 3'd7 && pending === 8'h80) passed++;
    else $display("FAIL line7_vector: got vec=%0d pend=%h, expected vec=7 pend=80", vector, pending);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
